// File: rtl/decompress_if.sv
// Handshake bundle between the compressed-block source, the decompressor and the pixel consumer.
// The source drives the input half of the bundle, and the consumer drives out_ready.
interface decompress_if #(
   parameter int NUM_PIX = 32,
   parameter int PIX_W   = 32
);
   localparam int LINE_W = NUM_PIX * PIX_W / 2;

   logic                         in_valid;
   logic                         in_ready;
   logic [1:0][LINE_W-1:0]       lines;
   logic [1:0]                   flag;
   logic                         out_valid;
   logic                         out_ready;
   logic [NUM_PIX*PIX_W-1:0]     out_pixels;
   logic                         out_err;

   modport master (
      output in_valid, lines, flag, out_ready,
      input  in_ready, out_valid, out_pixels, out_err
   );

   modport slave (
      input  in_valid, lines, flag, out_ready,
      output in_ready, out_valid, out_pixels, out_err
   );
endinterface

// File: rtl/decompress.sv
// Rebuilds a pixel block from two compressed lines (raw, constant or W-bit delta residuals).
// Delta blocks are decoded PIX_PER_CYCLE pixels per cycle, and the other formats are produced on the accept cycle.
module decompress #(
   parameter int NUM_PIX       = 32,
   parameter int PIX_W         = 32,
   parameter int PIX_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   decompress_if.slave  bus
);
   localparam int OUT_W  = NUM_PIX * PIX_W;
   localparam int LINE_W = OUT_W / 2;
   localparam int KW     = $clog2(NUM_PIX);
   localparam int LAST_K = NUM_PIX - PIX_PER_CYCLE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      OUT    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   l1_q, l1_d;
   logic [31:0]         base_q, base_d;
   logic [1:0]          w_q, w_d;
   logic [KW-1:0]       k_q, k_d;
   logic [OUT_W-1:0]    pixels_q, pixels_d;
   logic                err_q, err_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   // W-bit two's-complement residual whose LSB sits at bit 'off' of l1, widened to a channel.
   function automatic logic [7:0] residual(input logic [LINE_W-1:0] l1, input int off,
                                           input logic [1:0] w);
      logic [LINE_W-1:0] sh;
      sh = l1 >> off;
      case (w)
         2'd1:    residual = {{7{sh[0]}}, sh[0]};
         2'd2:    residual = {{6{sh[1]}}, sh[1:0]};
         2'd3:    residual = {{5{sh[2]}}, sh[2:0]};
         default: residual = 8'd0;
      endcase
   endfunction

   // Next-state, datapath updates and registered handshake outputs.
   always_comb begin
      state_d   = state_q;
      l1_d      = l1_q;
      base_d    = base_q;
      w_d       = w_q;
      k_d       = k_q;
      pixels_d  = pixels_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               l1_d  = bus.lines[0];
               err_d = 1'b0;
               case (bus.flag)
                  2'b00: begin
                     pixels_d = {bus.lines[1], bus.lines[0]};
                     state_d  = OUT;
                  end
                  2'b10: begin
                     for (int i = 0; i < NUM_PIX; i++) begin
                        pixels_d[i*PIX_W +: PIX_W] = bus.lines[0][PIX_W-1:0];
                     end
                     state_d = OUT;
                  end
                  2'b01: begin
                     base_d = bus.lines[0][31:0];
                     if ((bus.lines[0][35:32] >= 4'd1) && (bus.lines[0][35:32] <= 4'd3)) begin
                        w_d      = bus.lines[0][33:32];
                        k_d      = {KW{1'b0}};
                        pixels_d = {OUT_W{1'b0}};
                        state_d  = DECODE;
                     end else begin
                        pixels_d = {OUT_W{1'b0}};
                        err_d    = 1'b1;
                        state_d  = OUT;
                     end
                  end
                  default: begin
                     pixels_d = {OUT_W{1'b0}};
                     err_d    = 1'b1;
                     state_d  = OUT;
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         DECODE: begin
            for (int p = 0; p < PIX_PER_CYCLE; p++) begin
               for (int c = 0; c < 4; c++) begin
                  pixels_d[(int'(k_q) + p)*PIX_W + c*8 +: 8] =
                     base_q[c*8 +: 8] +
                     residual(l1_q, 36 + ((int'(k_q) + p)*4 + c)*int'(w_q), w_q);
               end
            end
            if (k_q == KW'(LAST_K)) begin
               state_d = OUT;
            end else begin
               k_d = k_q + KW'(PIX_PER_CYCLE);
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == OUT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         l1_q        <= {LINE_W{1'b0}};
         base_q      <= 32'd0;
         w_q         <= 2'd0;
         k_q         <= {KW{1'b0}};
         pixels_q    <= {OUT_W{1'b0}};
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         l1_q        <= l1_d;
         base_q      <= base_d;
         w_q         <= w_d;
         k_q         <= k_d;
         pixels_q    <= pixels_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_pixels = pixels_q;
   assign bus.out_err    = err_q;
endmodule
